// File: rtl/hci_bank_arbiter.sv
// rtl/hci_bank_arbiter.sv - per-bank TCDM arbiter: round-robin narrow group vs. wide HWPE branch
// Static group priority with a starvation override; 1-cycle response routing.
module hci_bank_arbiter #(
  parameter int N_NARROW             = 8,
  parameter int DW                   = 32,
  parameter int AW                   = 11,
  parameter int BW                   = 8,
  parameter bit FILTER_WRITE_R_VALID = 1'b0,
  parameter int STALL_W              = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clear_i,
  input  logic                     ctrl_invert_prio_i,
  input  logic [STALL_W-1:0]       ctrl_max_stall_i,
  input  logic [N_NARROW-1:0]      narrow_req_i,
  output logic [N_NARROW-1:0]      narrow_gnt_o,
  input  logic [N_NARROW*AW-1:0]   narrow_add_i,
  input  logic [N_NARROW-1:0]      narrow_wen_i,
  input  logic [N_NARROW*DW/BW-1:0] narrow_be_i,
  input  logic [N_NARROW*DW-1:0]   narrow_data_i,
  output logic [N_NARROW-1:0]      narrow_r_valid_o,
  output logic [DW-1:0]            narrow_r_data_o,
  input  logic                     wide_req_i,
  output logic                     wide_gnt_o,
  input  logic [AW-1:0]            wide_add_i,
  input  logic                     wide_wen_i,
  input  logic [DW/BW-1:0]         wide_be_i,
  input  logic [DW-1:0]            wide_data_i,
  output logic                     wide_r_valid_o,
  output logic [DW-1:0]            wide_r_data_o,
  output logic                     mem_req_o,
  input  logic                     mem_gnt_i,
  output logic [AW-1:0]            mem_add_o,
  output logic                     mem_wen_o,
  output logic [DW/BW-1:0]         mem_be_o,
  output logic [DW-1:0]            mem_data_o,
  input  logic [DW-1:0]            mem_r_data_i
);

  localparam int BEW = DW / BW;
  localparam int RRW = (N_NARROW > 1) ? $clog2(N_NARROW) : 1;

  logic [RRW-1:0]     r_rr_ptr;
  logic [STALL_W-1:0] r_stall_cnt;
  logic [N_NARROW:0]  r_resp_sel;
  logic               r_resp_wr;

  logic [RRW-1:0]     w_nidx;
  logic [RRW-1:0]     w_cand;
  logic               w_found;
  logic               w_narrow_any;
  logic               w_high_req;
  logic               w_low_req;
  logic               w_override;
  logic               w_low_wins;
  logic               w_sel_wide;
  logic               w_narrow_hs;
  logic               w_wide_hs;
  logic               w_high_hs;
  logic               w_low_hs;

  assign w_narrow_any = |narrow_req_i;

  // First requester at or after the pointer, wrapping.
  always_comb begin
    w_nidx  = '0;
    w_cand  = '0;
    w_found = 1'b0;
    for (int i = 0; i < N_NARROW; i++) begin
      w_cand = RRW'((int'(r_rr_ptr) + i) % N_NARROW);
      if (!w_found && narrow_req_i[w_cand]) begin
        w_nidx  = w_cand;
        w_found = 1'b1;
      end
    end
  end

  assign w_high_req = ctrl_invert_prio_i ? wide_req_i : w_narrow_any;
  assign w_low_req  = ctrl_invert_prio_i ? w_narrow_any : wide_req_i;
  assign w_override = (ctrl_max_stall_i != '0) && (r_stall_cnt >= ctrl_max_stall_i) && w_low_req;
  assign w_low_wins = w_override || !w_high_req;
  assign w_sel_wide = ctrl_invert_prio_i ? !w_low_wins : w_low_wins;

  assign mem_req_o  = w_narrow_any | wide_req_i;
  assign wide_gnt_o = w_sel_wide & wide_req_i & mem_gnt_i;

  always_comb begin
    narrow_gnt_o = '0;
    mem_add_o    = '0;
    mem_wen_o    = 1'b1;
    mem_be_o     = '0;
    mem_data_o   = '0;
    for (int i = 0; i < N_NARROW; i++) begin
      if (RRW'(i) == w_nidx) begin
        narrow_gnt_o[i] = !w_sel_wide && w_narrow_any && mem_gnt_i;
        mem_add_o       = narrow_add_i[i*AW +: AW];
        mem_wen_o       = narrow_wen_i[i];
        mem_be_o        = narrow_be_i[i*BEW +: BEW];
        mem_data_o      = narrow_data_i[i*DW +: DW];
      end
    end
    if (w_sel_wide) begin
      mem_add_o  = wide_add_i;
      mem_wen_o  = wide_wen_i;
      mem_be_o   = wide_be_i;
      mem_data_o = wide_data_i;
    end
  end

  assign w_narrow_hs = |narrow_gnt_o;
  assign w_wide_hs   = wide_gnt_o;
  assign w_high_hs   = ctrl_invert_prio_i ? w_wide_hs : w_narrow_hs;
  assign w_low_hs    = ctrl_invert_prio_i ? w_narrow_hs : w_wide_hs;

  generate
    if (N_NARROW > 1) begin : g_rr
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          r_rr_ptr <= '0;
        end else if (clear_i) begin
          r_rr_ptr <= '0;
        end else if (w_narrow_hs) begin
          r_rr_ptr <= (w_nidx == RRW'(N_NARROW - 1)) ? '0 : w_nidx + 1'b1;
        end
      end
    end else begin : g_no_rr
      assign r_rr_ptr = '0;
    end
  endgenerate

  // Low side starves only while the high side actually takes the bank.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_stall_cnt <= '0;
    end else if (clear_i || w_low_hs) begin
      r_stall_cnt <= '0;
    end else if (w_low_req && w_high_hs && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_resp_sel <= '0;
      r_resp_wr  <= 1'b0;
    end else if (clear_i) begin
      r_resp_sel <= '0;
      r_resp_wr  <= 1'b0;
    end else begin
      r_resp_sel <= {w_wide_hs, narrow_gnt_o};
      r_resp_wr  <= !mem_wen_o;
    end
  end

  // Clear also masks the response already in flight.
  assign narrow_r_valid_o = clear_i ? '0 : r_resp_sel[N_NARROW-1:0];
  assign wide_r_valid_o   = !clear_i && r_resp_sel[N_NARROW] && !(FILTER_WRITE_R_VALID && r_resp_wr);
  assign narrow_r_data_o  = mem_r_data_i;
  assign wide_r_data_o    = mem_r_data_i;

endmodule

// File: tb/tb_hci_bank_arbiter.sv
// tb/tb_hci_bank_arbiter.sv - directed self-checking bench for hci_bank_arbiter
module tb_hci_bank_arbiter;
  localparam int N  = 8;
  localparam int DW = 32;
  localparam int AW = 11;
  localparam int BW = 8;
  localparam int SW = 8;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic             clear_i = 1'b0;
  logic             ctrl_invert_prio_i = 1'b0;
  logic [SW-1:0]    ctrl_max_stall_i = '0;
  logic [N-1:0]     narrow_req_i = '0;
  logic [N-1:0]     narrow_gnt_o;
  logic [N*AW-1:0]  narrow_add_i = '0;
  logic [N-1:0]     narrow_wen_i = '1;
  logic [N*DW/BW-1:0] narrow_be_i = '1;
  logic [N*DW-1:0]  narrow_data_i = '0;
  logic [N-1:0]     narrow_r_valid_o;
  logic [DW-1:0]    narrow_r_data_o;
  logic             wide_req_i = 1'b0;
  logic             wide_gnt_o;
  logic [AW-1:0]    wide_add_i = '0;
  logic             wide_wen_i = 1'b1;
  logic [DW/BW-1:0] wide_be_i = '1;
  logic [DW-1:0]    wide_data_i = '0;
  logic             wide_r_valid_o;
  logic [DW-1:0]    wide_r_data_o;
  logic             mem_req_o;
  logic             mem_gnt_i = 1'b0;
  logic [AW-1:0]    mem_add_o;
  logic             mem_wen_o;
  logic [DW/BW-1:0] mem_be_o;
  logic [DW-1:0]    mem_data_o;
  logic [DW-1:0]    mem_r_data_i = '0;

  int n_cmp = 0;
  int n_err = 0;

  hci_bank_arbiter #(
    .N_NARROW(N), .DW(DW), .AW(AW), .BW(BW),
    .FILTER_WRITE_R_VALID(1'b1), .STALL_W(SW)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i),
    .ctrl_invert_prio_i(ctrl_invert_prio_i), .ctrl_max_stall_i(ctrl_max_stall_i),
    .narrow_req_i(narrow_req_i), .narrow_gnt_o(narrow_gnt_o), .narrow_add_i(narrow_add_i),
    .narrow_wen_i(narrow_wen_i), .narrow_be_i(narrow_be_i), .narrow_data_i(narrow_data_i),
    .narrow_r_valid_o(narrow_r_valid_o), .narrow_r_data_o(narrow_r_data_o),
    .wide_req_i(wide_req_i), .wide_gnt_o(wide_gnt_o), .wide_add_i(wide_add_i),
    .wide_wen_i(wide_wen_i), .wide_be_i(wide_be_i), .wide_data_i(wide_data_i),
    .wide_r_valid_o(wide_r_valid_o), .wide_r_data_o(wide_r_data_o),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_add_o(mem_add_o),
    .mem_wen_o(mem_wen_o), .mem_be_o(mem_be_o), .mem_data_o(mem_data_o),
    .mem_r_data_i(mem_r_data_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_cycle();
    narrow_req_i = '0;
    wide_req_i   = 1'b0;
    clear_i      = 1'b1;
    tick();
    clear_i      = 1'b0;
  endtask

  initial begin
    // reset, idle
    repeat (2) tick();
    rst_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #2;
      check("idle_mem_req", 32'(mem_req_o), 32'd0);
      check("idle_gnt", {23'd0, wide_gnt_o, narrow_gnt_o}, 32'd0);
      check("idle_rvalid", {23'd0, wide_r_valid_o, narrow_r_valid_o}, 32'd0);
      tick();
    end
    check("idle_stall", 32'(dut.r_stall_cnt), 32'd0);

    // narrow round robin, all reads
    narrow_req_i = 8'hFF;
    mem_gnt_i    = 1'b1;
    for (int k = 0; k < 9; k++) begin
      mem_r_data_i = 32'hA500_0000 + 32'(k);
      #2;
      check("rr_gnt", 32'(narrow_gnt_o), 32'(1) << (k % 8));
      check("rr_rvalid", 32'(narrow_r_valid_o), (k == 0) ? 32'd0 : (32'(1) << ((k - 1) % 8)));
      check("rr_rdata", narrow_r_data_o, 32'hA500_0000 + 32'(k));
      tick();
    end

    // wide priority with starvation threshold 3
    clear_cycle();
    ctrl_invert_prio_i = 1'b1;
    ctrl_max_stall_i   = 8'd3;
    wide_req_i         = 1'b1;
    narrow_req_i       = 8'h04;
    for (int k = 0; k < 12; k++) begin
      #2;
      check("stall_wgnt", 32'(wide_gnt_o), (k % 4 == 3) ? 32'd0 : 32'd1);
      check("stall_ngnt", 32'(narrow_gnt_o), (k % 4 == 3) ? 32'h04 : 32'd0);
      check("stall_wrv", 32'(wide_r_valid_o), (k > 0 && (k - 1) % 4 != 3) ? 32'd1 : 32'd0);
      check("stall_nrv", 32'(narrow_r_valid_o), (k > 0 && (k - 1) % 4 == 3) ? 32'h04 : 32'd0);
      tick();
    end

    // threshold disabled: narrow starves, counter saturates
    ctrl_max_stall_i = 8'd0;
    for (int k = 0; k < 50; k++) begin
      #2;
      check("nostall_ngnt", 32'(narrow_gnt_o), 32'd0);
      tick();
    end
    repeat (220) tick();
    check("stall_sat", 32'(dut.r_stall_cnt), 32'd255);
    ctrl_max_stall_i = 8'd200;
    #2;
    check("lower_thr_ngnt", 32'(narrow_gnt_o), 32'h04);
    check("lower_thr_wgnt", 32'(wide_gnt_o), 32'd0);
    tick();
    check("lower_thr_clr", 32'(dut.r_stall_cnt), 32'd0);

    // wide write filtered, wide read responded
    clear_cycle();
    ctrl_invert_prio_i = 1'b0;
    ctrl_max_stall_i   = 8'd0;
    wide_req_i = 1'b1;
    wide_wen_i = 1'b0;
    wide_add_i = 11'h7AB;
    #2;
    check("wwr_gnt", 32'(wide_gnt_o), 32'd1);
    check("wwr_add", 32'(mem_add_o), 32'h7AB);
    check("wwr_wen", 32'(mem_wen_o), 32'd0);
    tick();
    wide_wen_i = 1'b1;
    #2;
    check("wwr_rvalid", 32'(wide_r_valid_o), 32'd0);
    check("wrd_gnt", 32'(wide_gnt_o), 32'd1);
    tick();
    wide_req_i   = 1'b0;
    mem_r_data_i = 32'hCAFE_F00D;
    #2;
    check("wrd_rvalid", 32'(wide_r_valid_o), 32'd1);
    check("wrd_rdata", wide_r_data_o, 32'hCAFE_F00D);
    tick();
    wide_req_i = 1'b1;
    tick();
    wide_req_i = 1'b0;
    clear_i    = 1'b1;
    #2;
    check("clr_suppress", 32'(wide_r_valid_o), 32'd0);
    tick();
    clear_i = 1'b0;

    // mem_gnt low holds everything, then port 2, port 3, async reset
    narrow_req_i = 8'h0C;
    narrow_add_i[2*AW +: AW] = 11'h123;
    mem_gnt_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #2;
      check("nogrant_gnt", 32'(narrow_gnt_o), 32'd0);
      check("nogrant_req", 32'(mem_req_o), 32'd1);
      check("nogrant_ptr", 32'(dut.r_rr_ptr), 32'd0);
      tick();
    end
    mem_gnt_i = 1'b1;
    #2;
    check("p2_gnt", 32'(narrow_gnt_o), 32'h04);
    check("p2_add", 32'(mem_add_o), 32'h123);
    tick();
    #2;
    check("p3_gnt", 32'(narrow_gnt_o), 32'h08);
    check("p2_rvalid", 32'(narrow_r_valid_o), 32'h04);
    tick();
    #2;
    check("p3_rvalid", 32'(narrow_r_valid_o), 32'h08);
    #1;
    rst_i = 1'b1;
    #1;
    check("arst_rvalid", 32'(narrow_r_valid_o), 32'd0);
    check("arst_ptr", 32'(dut.r_rr_ptr), 32'd0);
    tick();
    rst_i = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
